add_sched: RTL and testbench

Multi-precision add/subtract scheduler that shares one 8-bit `adder` instance between two requesters. Each accepted request is a WIDTH_BYTES-byte add or subtract. The block processes it byte-serially, least-significant byte first, and chains the carry through a register. It sits between two operand producers and one result consumer, and is the only owner of the adder.

---
 rtl/add_sched_pkg.sv | 23 ++
 rtl/add_sched_adder.sv | 22 ++
 rtl/add_sched.sv | 174 +++++++++++++++++
 tb/tb_add_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared definitions for the add_sched byte-serial add/subtract
// scheduler.
//   - state encodings (IDLE, CALC, DONE) as an enum and as plain constants
//   - operation codes OP_ADD / OP_SUB for the reqN_sub inputs
//   - default operand width in bytes
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH_BYTES = 4;

endpackage

// File: rtl/add_sched_adder.sv
// adder: the shared 8-bit adder with carry in/out.
// Ports:
//   x, y  in  8  addends
//   cin   in  1  carry in
//   sum   out 8  x + y + cin (low 8 bits)
//   cout  out 1  carry out of bit 7
module adder
    import add_sched_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // 9-bit add so the carry out falls out of the top bit.
    always_comb begin
        {cout, sum} = 9'(x) + 9'(y) + 9'(cin);
    end

endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler that shares one 8-bit adder between two
// requesters and performs WIDTH_BYTES-byte add/subtract byte-serially,
// least-significant byte first, with the carry chained through a register.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            request handshake (N = 0, 1); ready is
//                               combinational from valid and the priority
//   reqN_a, reqN_b, reqN_sub    operands and operation (0 = a+b, 1 = a-b)
//   rsp_valid/ready             response handshake
//   rsp_id                      requester that issued the result
//   rsp_sum, rsp_cout, rsp_ovf  result, final carry (1 = no borrow on
//                               subtract), signed overflow
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH_BYTES = DEFAULT_WIDTH_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [8*WIDTH_BYTES-1:0] req0_a,
    input  logic [8*WIDTH_BYTES-1:0] req0_b,
    input  logic                     req0_sub,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [8*WIDTH_BYTES-1:0] req1_a,
    input  logic [8*WIDTH_BYTES-1:0] req1_b,
    input  logic                     req1_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [8*WIDTH_BYTES-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    localparam int W  = 8 * WIDTH_BYTES;
    localparam int KW = (WIDTH_BYTES > 1) ? $clog2(WIDTH_BYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH_BYTES - 1);

    logic [1:0]    state_r;
    logic          prio_r;
    logic          id_r;
    logic          carry_r;
    logic [KW-1:0] k_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;       // already inverted for subtract
    logic [W-1:0]  res_r;
    logic          rsp_valid_r;
    logic          rsp_cout_r;
    logic          rsp_ovf_r;

    logic          idle_s;
    logic          grant_s;
    logic          accept_s;
    logic          sub_s;
    logic [W-1:0]  a_sel_s;
    logic [W-1:0]  b_eff_s;
    logic [7:0]    x_s;
    logic [7:0]    y_s;
    logic [7:0]    add_sum_s;
    logic          add_cout_s;
    logic          ovf_s;

    // Arbitration: prio breaks ties, a lone requester always wins.
    always_comb begin
        idle_s = (state_r == ST_IDLE) && !rst;
        if (req0_valid && req1_valid) begin
            grant_s = prio_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        req0_ready = idle_s && req0_valid && (grant_s == 1'b0);
        req1_ready = idle_s && req1_valid && (grant_s == 1'b1);
        accept_s   = req0_ready || req1_ready;
    end

    // Operand selection for the winning requester; subtract becomes
    // a + ~b + 1, the +1 entering as the initial carry.
    always_comb begin
        if (grant_s) begin
            sub_s   = req1_sub;
            a_sel_s = req1_a;
            b_eff_s = (req1_sub == OP_SUB) ? ~req1_b : req1_b;
        end else begin
            sub_s   = req0_sub;
            a_sel_s = req0_a;
            b_eff_s = (req0_sub == OP_SUB) ? ~req0_b : req0_b;
        end
    end

    // Byte k of the captured operands feeds the shared adder.
    always_comb begin
        x_s   = a_r[{k_r, 3'b000} +: 8];
        y_s   = b_r[{k_r, 3'b000} +: 8];
        // Only meaningful on the top byte, where add_sum_s[7] is the result sign.
        ovf_s = (a_r[W-1] == b_r[W-1]) && (add_sum_s[7] != a_r[W-1]);
    end

    adder u_adder (
        .x    (x_s),
        .y    (y_s),
        .cin  (carry_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prio_r      <= 1'b0;
            id_r        <= 1'b0;
            carry_r     <= 1'b0;
            k_r         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            res_r       <= '0;
            rsp_valid_r <= 1'b0;
            rsp_cout_r  <= 1'b0;
            rsp_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a_sel_s;
                        b_r     <= b_eff_s;
                        carry_r <= (sub_s == OP_SUB);
                        id_r    <= grant_s;
                        k_r     <= '0;
                        state_r <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    res_r[{k_r, 3'b000} +: 8] <= add_sum_s;
                    carry_r <= add_cout_s;
                    if (k_r == K_LAST) begin
                        k_r         <= '0;
                        rsp_valid_r <= 1'b1;
                        rsp_cout_r  <= add_cout_s;
                        rsp_ovf_r   <= ovf_s;
                        state_r     <= ST_DONE;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        prio_r      <= ~id_r;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = id_r;
    assign rsp_sum   = res_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: directed self-checking bench for add_sched (WIDTH_BYTES = 4).
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_add_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [31:0] rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    add_sched #(.WIDTH_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise valid on requester id, wait (bounded) for ready, cross the accept
    // edge and drop valid. Returns 1 unit into the first CALC cycle.
    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        int waited = 0;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check_eq("req_ready", {63'd0, (id ? req1_ready : req0_ready)}, 64'd1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Cycles counted from the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] sum,
                             input logic cout, input logic ovf);
        check_eq({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        check_eq({tag, "_id"},    {63'd0, rsp_id},    {63'd0, id});
        check_eq({tag, "_sum"},   {32'd0, rsp_sum},   {32'd0, sum});
        check_eq({tag, "_cout"},  {63'd0, rsp_cout},  {63'd0, cout});
        check_eq({tag, "_ovf"},   {63'd0, rsp_ovf},   {63'd0, ovf});
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("rsp_valid_after_hs", {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_r0rdy"}, {63'd0, req0_ready}, 64'd0);
        check_eq({tag, "_r1rdy"}, {63'd0, req1_ready}, 64'd0);
        check_eq({tag, "_valid"}, {63'd0, rsp_valid},  64'd0);
        check_eq({tag, "_id"},    {63'd0, rsp_id},     64'd0);
        check_eq({tag, "_sum"},   {32'd0, rsp_sum},    64'd0);
        check_eq({tag, "_cout"},  {63'd0, rsp_cout},   64'd0);
        check_eq({tag, "_ovf"},   {63'd0, rsp_ovf},    64'd0);
    endtask

    task automatic do_op(input string tag, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic sub, input logic [31:0] sum,
                         input logic cout, input logic ovf);
        int lat;
        issue(id, a, b, sub);
        wait_rsp(lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'd5);
        check_rsp(tag, id, sum, cout, ovf);
        handshake();
    endtask

    initial begin
        int lat;
        int last;
        logic seen;

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_sub = 1'b0;
        rsp_ready  = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single add, subtract with/without borrow, overflow and carry cases.
        do_op("add_ff_1",   1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        do_op("sub_5_7",    1'b1, 32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_7_5",    1'b0, 32'd7,         32'd5,         1'b1, 32'd2,         1'b1, 1'b0);
        do_op("add_ovf",    1'b1, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("add_carry",  1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, 1'b1, 1'b0);

        // Arbitration from reset: both valid, rsp_ready high, grants alternate.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_a = 32'h10;  req0_b = 32'h01; req0_sub = 1'b0; req0_valid = 1'b1;
        req1_a = 32'h100; req1_b = 32'h20; req1_sub = 1'b1; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        last = 0;
        for (int n = 0; n < 4; n++) begin
            lat = 0;
            while (!rsp_valid && lat < 30) begin
                step();
                lat++;
            end
            check_eq("arb_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("arb_id",    {63'd0, rsp_id},    64'(n % 2));
            check_eq("arb_sum",   {32'd0, rsp_sum},   (n % 2 == 1) ? 64'h0E0 : 64'h011);
            check_eq("arb_cout",  {63'd0, rsp_cout},  64'(n % 2));
            if (n > 0) check_eq("arb_spacing", 64'(cyc - last), 64'd6);
            last = cyc;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;

        // Backpressure: rsp held 3 cycles, both readies low with req1 waiting.
        issue(1'b0, 32'd3, 32'd4, 1'b0);
        wait_rsp(lat);
        check_eq("bp_latency", 64'(lat), 64'd5);
        req1_a = 32'd9; req1_b = 32'd1; req1_sub = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_rsp("bp_hold", 1'b0, 32'd7, 1'b0, 1'b0);
            check_eq("bp_r0rdy", {63'd0, req0_ready}, 64'd0);
            check_eq("bp_r1rdy", {63'd0, req1_ready}, 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("bp_next_ready", {63'd0, req1_ready}, 64'd1);
        step();
        req1_valid = 1'b0;
        wait_rsp(lat);
        check_eq("bp_next_latency", 64'(lat), 64'd5);
        check_rsp("bp_next", 1'b1, 32'd10, 1'b0, 1'b0);
        handshake();

        // Reset while k = 2: everything clears and no response appears.
        issue(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midrst");
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen = 1'b1;
            step();
        end
        check_eq("midrst_no_rsp", {63'd0, seen}, 64'd0);
        do_op("after_rst", 1'b0, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
